// File: rtl/pc_seq_pkg.sv
// Shared constants, interrupt state type and condition evaluation for pc_sequencer.
package pc_seq_pkg;

  // Instruction classes
  localparam logic [3:0] OP_JUMP  = 4'b0100;
  localparam logic [3:0] OP_BCOND = 4'b1100;

  // JUMP subtypes
  localparam logic [3:0] SUB_JAL   = 4'b1000;
  localparam logic [3:0] SUB_JCOND = 4'b1100;
  localparam logic [3:0] SUB_RETI  = 4'b1110;
  localparam logic [3:0] SUB_RET   = 4'b1111;

  // Condition codes
  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_HI = 4'b0100;
  localparam logic [3:0] CC_LS = 4'b0101;
  localparam logic [3:0] CC_GT = 4'b0110;
  localparam logic [3:0] CC_LE = 4'b0111;
  localparam logic [3:0] CC_FS = 4'b1000;
  localparam logic [3:0] CC_FC = 4'b1001;
  localparam logic [3:0] CC_LO = 4'b1010;
  localparam logic [3:0] CC_HS = 4'b1011;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GE = 4'b1101;
  localparam logic [3:0] CC_UC = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  // PSR flag bit positions
  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;

  // Interrupt nesting state: a single level of ISR is supported
  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ISR = 1'b1
  } irq_state_e;

  // Evaluate a condition code against the PSR flags
  function automatic logic cond_true(input logic [3:0] cond, input logic [15:0] psr);
    logic c, l, f, z, n;
    c = psr[PSR_C];
    l = psr[PSR_L];
    f = psr[PSR_F];
    z = psr[PSR_Z];
    n = psr[PSR_N];
    case (cond)
      CC_EQ:   cond_true = z;
      CC_NE:   cond_true = !z;
      CC_CS:   cond_true = c;
      CC_CC:   cond_true = !c;
      CC_HI:   cond_true = l;
      CC_LS:   cond_true = !l;
      CC_GT:   cond_true = n;
      CC_LE:   cond_true = !n;
      CC_FS:   cond_true = f;
      CC_FC:   cond_true = !f;
      CC_LO:   cond_true = !l && !z;
      CC_HS:   cond_true = l || z;
      CC_LT:   cond_true = !n && !z;
      CC_GE:   cond_true = n || z;
      CC_UC:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pc_sequencer_link_stack.sv
// Circular LIFO of return addresses; a push while full overwrites the oldest entry.
module link_stack
  import pc_seq_pkg::*;
#(
  parameter int PC_W        = 16,
  parameter int STACK_DEPTH = 8,
  parameter int SP_W        = $clog2(STACK_DEPTH),
  parameter int CNT_W       = $clog2(STACK_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [PC_W-1:0]  i_data,
  output logic [PC_W-1:0]  o_top,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_full,
  output logic             o_empty
);

  logic [PC_W-1:0]  r_mem [STACK_DEPTH];
  logic [SP_W-1:0]  r_sp;
  logic [CNT_W-1:0] r_cnt;
  logic [SP_W-1:0]  w_sp_top;

  assign w_sp_top = r_sp - SP_W'(1);
  assign o_top    = r_mem[w_sp_top];
  assign o_cnt    = r_cnt;
  assign o_full   = (r_cnt == CNT_W'(STACK_DEPTH));
  assign o_empty  = (r_cnt == '0);

  // Entry storage: written on push at the free slot, never cleared by reset
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_sp] <= i_data;
    end
  end

  // Pointer and occupancy: the pointer wraps, the count saturates at the depth
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_sp  <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_sp <= r_sp + SP_W'(1);
      if (!o_full) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if (i_pop && !o_empty) begin
      r_sp  <= w_sp_top;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: single-cycle next-PC selection, link stack and one-level interrupts.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W        = 16,
  parameter int              STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [PC_W-1:0] IRQ_VEC     = PC_W'(16'h0010)
) (
  input  logic                           clk,
  input  logic                           Reset,
  input  logic                           PCen,
  input  logic [3:0]                     Opcode,
  input  logic [3:0]                     OpcodeExt_dispHi,
  input  logic [3:0]                     dispLo,
  input  logic [3:0]                     CondRlink,
  input  logic [15:0]                    PSR,
  input  logic [PC_W-1:0]                RegData,
  input  logic                           irq,
  input  logic                           clr_err,
  output logic [PC_W-1:0]                PC,
  output logic                           irq_ack,
  output logic                           in_irq,
  output logic [$clog2(STACK_DEPTH):0]   stack_cnt,
  output logic                           stack_full,
  output logic                           stack_empty,
  output logic                           stack_ovf,
  output logic                           stack_unf
);

  localparam int CNT_W = $clog2(STACK_DEPTH) + 1;

  logic [PC_W-1:0]   r_pc;
  logic              r_irq_ack;
  logic              r_ovf;
  logic              r_unf;
  irq_state_e        r_state;

  irq_state_e        w_state_next;
  logic [PC_W-1:0]   w_pc_next;
  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_push_data;
  logic [PC_W-1:0]   w_top;
  logic [PC_W-1:0]   w_disp_ext;
  logic signed [7:0] w_disp8;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_cond;
  logic              w_ack_next;
  logic              w_set_ovf;
  logic              w_set_unf;

  assign w_pc_inc   = r_pc + PC_W'(1);
  assign w_disp8    = {OpcodeExt_dispHi, dispLo};
  assign w_disp_ext = PC_W'(w_disp8);
  assign w_cond     = cond_true(CondRlink, PSR);
  assign w_set_ovf  = w_push && w_full;

  link_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_link_stack (
    .clk     (clk),
    .i_rst_n (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_top   (w_top),
    .o_cnt   (w_cnt),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next-PC mux, stack requests and interrupt state transitions
  always_comb begin
    w_pc_next    = r_pc;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_push_data  = w_pc_inc;
    w_ack_next   = 1'b0;
    w_set_unf    = 1'b0;
    w_state_next = r_state;
    if (PCen) begin
      if (irq && (r_state == ST_RUN)) begin
        // Push the interrupted PC itself so that instruction re-executes on return
        w_push       = 1'b1;
        w_push_data  = r_pc;
        w_pc_next    = IRQ_VEC;
        w_ack_next   = 1'b1;
        w_state_next = ST_ISR;
      end else begin
        w_pc_next = w_pc_inc;
        case (Opcode)
          OP_JUMP: begin
            case (OpcodeExt_dispHi)
              SUB_JAL: begin
                w_push    = 1'b1;
                w_pc_next = RegData;
              end
              SUB_JCOND: begin
                if (w_cond) begin
                  w_pc_next = RegData;
                end
              end
              SUB_RET, SUB_RETI: begin
                if (!w_empty) begin
                  w_pop     = 1'b1;
                  w_pc_next = w_top;
                end else begin
                  w_set_unf = 1'b1;
                end
                if (OpcodeExt_dispHi == SUB_RETI) begin
                  w_state_next = ST_RUN;
                end
              end
              default: ;
            endcase
          end
          OP_BCOND: begin
            if (w_cond) begin
              w_pc_next = r_pc + w_disp_ext;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Interrupt state register
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // PC register and one-cycle interrupt acknowledge (low on hold cycles)
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_pc      <= RESET_PC;
      r_irq_ack <= 1'b0;
    end else begin
      r_pc      <= w_pc_next;
      r_irq_ack <= w_ack_next;
    end
  end

  // Sticky stack error flags; a new error outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (PCen) begin
      r_ovf <= w_set_ovf || (r_ovf && !clr_err);
      r_unf <= w_set_unf || (r_unf && !clr_err);
    end
  end

  assign PC          = r_pc;
  assign irq_ack     = r_irq_ack;
  assign in_irq      = (r_state == ST_ISR);
  assign stack_cnt   = w_cnt;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign stack_ovf   = r_ovf;
  assign stack_unf   = r_unf;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the CPU core. It holds the PC and resolves, in one cycle, the next PC from the current Opcode, condition code and PSR flags. It supports register jumps, PC-relative conditional branches, a configurable-depth hardware link stack and a single-level interrupt entry/return. It sits between the instruction decoder/register file and instruction memory. It adds width, depth and vector parameters, stack status and error reporting, and interrupt handling beyond the previous PC controller.

## Interface
- PC_W, 16: PC and RegData width, ≥ 8.
- STACK_DEPTH, 8: link-stack entries, power of two, ≥ 2.
- RESET_PC, 0: PC value after reset.
- IRQ_VEC, 16'h0010: interrupt entry address.
- clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low; clock clk.
- PCen  in  1  advance enable; low holds all state.
- Opcode  in  4  instruction class; JUMP=4'b0100, BCOND=4'b1100, other values are non-flow.
- OpcodeExt_dispHi  in  4  JUMP subtype (JAL=1000, JCOND=1100, RETI=1110, RET=1111), or displacement[7:4] for BCOND.
- dispLo  in  4  displacement[3:0].
- CondRlink  in  4  condition code.
- PSR  in  16  flags: C=[0], L=[2], F=[5], Z=[6], N=[7].
- RegData  in  PC_W  jump target.
- irq  in  1  level interrupt request.
- clr_err  in  1  clears the sticky error flags.
- PC  out  PC_W  current PC; reset value RESET_PC.
- irq_ack  out  1  one-cycle pulse on interrupt entry; reset value 0.
- in_irq  out  1  high while an ISR is active; reset value 0.
- stack_cnt  out  $clog2(STACK_DEPTH)+1  occupied entries; reset value 0.
- stack_full, stack_empty  out  1  combinational from stack_cnt; reset values 0 and 1.
- stack_ovf, stack_unf  out  1  sticky error flags; reset value 0.

## Operation
- Condition true when: EQ(0000) Z; NE(0001) !Z; CS(0010) C; CC(0011) !C; HI(0100) L; LS(0101) !L; GT(0110) N; LE(0111) !N; FS(1000) F; FC(1001) !F; LO(1010) !L&!Z; HS(1011) L|Z; LT(1100) !N&!Z; GE(1101) N|Z; UC(1110) 1; 1111 false.
- Priority order: Reset, then !PCen (hold), then interrupt take, then instruction.
- Interrupt take, when irq & !in_irq & PCen:
  - push the current PC, so the interrupted instruction re-executes after return;
  - PC←IRQ_VEC, in_irq←1, irq_ack←1;
  - the instruction on the inputs that cycle is discarded.
- JAL: push PC+1, PC←RegData.
- JCOND: PC←RegData if the condition is true, else PC+1.
- RET: if stack not empty, PC←top and pop. If empty, PC←PC+1, stack_unf←1.
- RETI: same as RET, and additionally in_irq←0. RETI with in_irq=0 behaves as RET.
- BCOND: if the condition is true, PC←PC+sext(dispHi:dispLo) from 8 bits to PC_W; else PC+1.
- Undefined JUMP subtypes and all non-flow opcodes: PC←PC+1.
- All PC arithmetic wraps modulo 2^PC_W.
- Push while full:
  - stack is circular; the new entry overwrites the oldest;
  - stack_cnt stays at STACK_DEPTH;
  - stack_ovf←1.
- Sticky flags: clr_err clears them. A set event in the same cycle as clr_err wins.
- Reset mid-operation: PC, stack pointer, count, in_irq, irq_ack and flags return to reset values. Stack storage is not cleared.

## Timing
- Single-cycle next-PC: inputs are sampled at edge k; PC, stack and flags are valid after edge k.
- irq_ack is high exactly one cycle per take, and is low during any hold cycle.
- Return address pushed is PC+1 for JAL and PC for an interrupt, using the pre-edge PC.
- Push and pop never occur in the same cycle.
- Pop reads the pre-edge top entry.

## Structure
- pc_seq_pkg holds: opcode, subtype and condition-code localparams; PSR bit-index constants; the cond_true(cond, psr) function.
- Sub-module link_stack: parametrised circular LIFO with push, pop, top, cnt, full, empty and overflow-wrap.
- The top level holds the PC register, next-PC mux, interrupt state and sticky flags.

## Test plan
- Reset low with PCen=1 and Opcode=JUMP/JAL → PC=RESET_PC, stack_cnt=0, no push.
- BCOND UC with disp=8'hFE at PC=0x0005 → PC=0x0003. With disp=8'h7F at PC=0xFFF0 → PC=0x006F (wrap).
- Nine JALs with STACK_DEPTH=8, then eight RETs → return addresses match the last eight pushes, stack_ovf=1. A ninth RET → PC+1, stack_unf=1.
- BCOND over all 16 condition codes × PSR patterns {0, C, L, F, Z, N, L|Z, N|Z} → taken/not-taken exactly per the condition table; code 1111 never taken.
- irq at PC=0x0040 while a JAL is presented → PC=IRQ_VEC, irq_ack pulses 1 cycle, JAL not executed. A second irq is ignored. RETI → PC=0x0040, in_irq=0.
- clr_err and an underflow in the same cycle → stack_unf=1. PCen=0 with irq high → PC held, irq_ack=0.
